// File: rtl/lcd_timing_pkg.sv
// Shared 1280x720 timing defaults, bus widths and test-bar colours for the LCD driver.
package lcd_timing_pkg;

    localparam int CNT_W = 12;
    localparam int POS_W = 11;
    localparam int RGB_W = 24;

    localparam int DEF_H_SYNC  = 40;
    localparam int DEF_H_BACK  = 220;
    localparam int DEF_H_DISP  = 1280;
    localparam int DEF_H_TOTAL = 1650;
    localparam int DEF_V_SYNC  = 5;
    localparam int DEF_V_BACK  = 20;
    localparam int DEF_V_DISP  = 720;
    localparam int DEF_V_TOTAL = 750;

    localparam logic [RGB_W-1:0] WHITE   = 24'hFFFFFF;
    localparam logic [RGB_W-1:0] YELLOW  = 24'hFFFF00;
    localparam logic [RGB_W-1:0] CYAN    = 24'h00FFFF;
    localparam logic [RGB_W-1:0] GREEN   = 24'h00FF00;
    localparam logic [RGB_W-1:0] MAGENTA = 24'hFF00FF;
    localparam logic [RGB_W-1:0] RED     = 24'hFF0000;
    localparam logic [RGB_W-1:0] BLUE    = 24'h0000FF;
    localparam logic [RGB_W-1:0] BLACK   = 24'h000000;

    typedef enum logic [2:0] {
        BAR_WHITE, BAR_YELLOW, BAR_CYAN, BAR_GREEN,
        BAR_MAGENTA, BAR_RED, BAR_BLUE, BAR_BLACK
    } bar_e;

    function automatic logic [RGB_W-1:0] bar_colour(input bar_e b);
        case (b)
            BAR_WHITE:   return WHITE;
            BAR_YELLOW:  return YELLOW;
            BAR_CYAN:    return CYAN;
            BAR_GREEN:   return GREEN;
            BAR_MAGENTA: return MAGENTA;
            BAR_RED:     return RED;
            BAR_BLUE:    return BLUE;
            default:     return BLACK;
        endcase
    endfunction

endpackage

// File: rtl/lcd_pattern_gen.sv
// Eight equal-width vertical colour bars selected from the active-area column.
// Only instantiated when LCD_TEST_PATTERN_EN is defined.
module lcd_pattern_gen
    import lcd_timing_pkg::*;
#(
    parameter int H_DISP = DEF_H_DISP
) (
    input  logic [POS_W-1:0] xpos_i,
    output logic [RGB_W-1:0] colour_o
);

    localparam int BAR_W = H_DISP / 8;

    bar_e bar;

    // Threshold ladder instead of a divider: the last bar boundary crossed wins.
    always_comb begin
        bar = BAR_WHITE;
        for (int k = 1; k < 8; k++) begin
            if (int'(xpos_i) >= k * BAR_W) bar = bar_e'(3'(k));
        end
    end

    assign colour_o = bar_colour(bar);

endmodule

// File: rtl/lcd_driver.sv
// Parameterised LCD timing generator: sync/DE timing, pixel request one cycle ahead of DE,
// registered outputs. Optional colour-bar test pattern under LCD_TEST_PATTERN_EN.
module lcd_driver
    import lcd_timing_pkg::*;
#(
    parameter int H_SYNC  = DEF_H_SYNC,
    parameter int H_BACK  = DEF_H_BACK,
    parameter int H_DISP  = DEF_H_DISP,
    parameter int H_TOTAL = DEF_H_TOTAL,
    parameter int V_SYNC  = DEF_V_SYNC,
    parameter int V_BACK  = DEF_V_BACK,
    parameter int V_DISP  = DEF_V_DISP,
    parameter int V_TOTAL = DEF_V_TOTAL
) (
    input  logic             lcd_clk,
    input  logic             sys_rst_n,
    input  logic [RGB_W-1:0] pixel_data,
`ifdef LCD_TEST_PATTERN_EN
    input  logic             pattern_en,
`endif
    output logic [POS_W-1:0] pixel_xpos,
    output logic [POS_W-1:0] pixel_ypos,
    output logic             data_req,
    output logic             lcd_hs,
    output logic             lcd_vs,
    output logic             lcd_de,
    output logic [RGB_W-1:0] lcd_rgb,
    output logic             frame_start
);

    // Request window opens one clock before the visible area so the registered DE lands on it.
    localparam logic [CNT_W-1:0] REQ_H_FIRST = CNT_W'(H_SYNC + H_BACK - 1);
    localparam logic [CNT_W-1:0] REQ_H_LAST  = CNT_W'(H_SYNC + H_BACK + H_DISP - 2);
    localparam logic [CNT_W-1:0] REQ_V_FIRST = CNT_W'(V_SYNC + V_BACK);
    localparam logic [CNT_W-1:0] REQ_V_LAST  = CNT_W'(V_SYNC + V_BACK + V_DISP - 1);
    localparam logic [CNT_W-1:0] H_LAST      = CNT_W'(H_TOTAL - 1);
    localparam logic [CNT_W-1:0] V_LAST      = CNT_W'(V_TOTAL - 1);
    localparam logic [CNT_W-1:0] H_SYNC_C    = CNT_W'(H_SYNC);
    localparam logic [CNT_W-1:0] V_SYNC_C    = CNT_W'(V_SYNC);

    logic [CNT_W-1:0] h_cnt_q, h_cnt_d;
    logic [CNT_W-1:0] v_cnt_q, v_cnt_d;
    logic             de_q, hs_q, vs_q, fs_q;
    logic [RGB_W-1:0] rgb_q, rgb_d;
    logic [RGB_W-1:0] src_rgb;

    always_comb begin
        h_cnt_d = h_cnt_q + 1'b1;
        v_cnt_d = v_cnt_q;
        if (h_cnt_q == H_LAST) begin
            h_cnt_d = '0;
            v_cnt_d = (v_cnt_q == V_LAST) ? '0 : v_cnt_q + 1'b1;
        end
    end

    assign data_req = (h_cnt_q >= REQ_H_FIRST) && (h_cnt_q <= REQ_H_LAST) &&
                      (v_cnt_q >= REQ_V_FIRST) && (v_cnt_q <= REQ_V_LAST);

    assign pixel_xpos = data_req ? POS_W'(h_cnt_q - REQ_H_FIRST) : '0;
    assign pixel_ypos = data_req ? POS_W'(v_cnt_q - REQ_V_FIRST) : '0;

`ifdef LCD_TEST_PATTERN_EN
    logic [RGB_W-1:0] bar_rgb;

    lcd_pattern_gen #(.H_DISP(H_DISP)) u_pattern (
        .xpos_i   (pixel_xpos),
        .colour_o (bar_rgb)
    );

    assign src_rgb = pattern_en ? bar_rgb : pixel_data;
`else
    assign src_rgb = pixel_data;
`endif

    assign rgb_d = data_req ? src_rgb : '0;

    always_ff @(posedge lcd_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            h_cnt_q <= '0;
            v_cnt_q <= '0;
            de_q    <= 1'b0;
            rgb_q   <= '0;
            hs_q    <= 1'b1;
            vs_q    <= 1'b1;
            fs_q    <= 1'b0;
        end else begin
            h_cnt_q <= h_cnt_d;
            v_cnt_q <= v_cnt_d;
            de_q    <= data_req;
            rgb_q   <= rgb_d;
            hs_q    <= !(h_cnt_q < H_SYNC_C);
            vs_q    <= !(v_cnt_q < V_SYNC_C);
            fs_q    <= (h_cnt_q == '0) && (v_cnt_q == '0);
        end
    end

    assign lcd_de      = de_q;
    assign lcd_rgb     = rgb_q;
    assign lcd_hs      = hs_q;
    assign lcd_vs      = vs_q;
    assign frame_start = fs_q;

endmodule
